branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 111 +++++++++++
 tb/tb_branch_predictor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Gshare direction predictor (global history XOR PC into a 2-bit counter PHT) plus a
// direct-mapped BTB. Lookups are combinational; updates from AGEX land on the next edge.
module branch_predictor #(
    parameter int DBITS        = 32,
    parameter int BHR_BITS     = 8,
    parameter int BTB_IDX_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DBITS-1:0]        fe_pc,
    output logic                    pred_taken,
    output logic                    pred_btb_hit,
    output logic [DBITS-1:0]        pred_target,
    output logic [BHR_BITS-1:0]     pred_bhr,
    output logic [BHR_BITS-1:0]     pred_pht_index,
    output logic [1:0]              pred_pht_entry,
    output logic [BTB_IDX_BITS-1:0] pred_btb_index,
    input  logic                    upd_valid,
    input  logic                    upd_cond,
    input  logic [DBITS-1:0]        upd_pc,
    input  logic                    upd_taken,
    input  logic [DBITS-1:0]        upd_target,
    input  logic [BHR_BITS-1:0]     upd_pht_index,
    input  logic                    upd_mispredict,
    output logic [31:0]             stat_branches,
    output logic [31:0]             stat_mispredicts
);
    localparam int PHT_N = 1 << BHR_BITS;
    localparam int BTB_N = 1 << BTB_IDX_BITS;
    localparam int TAG_W = DBITS - BTB_IDX_BITS - 2;

    logic [1:0]          r_pht     [PHT_N];
    logic [BHR_BITS-1:0] r_bhr;
    logic                r_btb_vld [BTB_N];
    logic [TAG_W-1:0]    r_btb_tag [BTB_N];
    logic [DBITS-1:0]    r_btb_tgt [BTB_N];
    logic [31:0]         r_stat_br;
    logic [31:0]         r_stat_mp;

    logic [BHR_BITS-1:0]     w_pht_idx;
    logic [BTB_IDX_BITS-1:0] w_btb_idx;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_hit;
    logic [BTB_IDX_BITS-1:0] w_upd_btb_idx;
    logic [TAG_W-1:0]        w_upd_tag;
    logic                    w_upd_en;
    logic                    w_unused;

    function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign w_pht_idx     = fe_pc[BHR_BITS+1:2] ^ r_bhr;
    assign w_btb_idx     = fe_pc[BTB_IDX_BITS+1:2];
    assign w_tag         = fe_pc[DBITS-1:BTB_IDX_BITS+2];
    assign w_hit         = r_btb_vld[w_btb_idx] && (r_btb_tag[w_btb_idx] == w_tag);
    assign w_upd_btb_idx = upd_pc[BTB_IDX_BITS+1:2];
    assign w_upd_tag     = upd_pc[DBITS-1:BTB_IDX_BITS+2];
    assign w_upd_en      = upd_valid && !reset;
    assign w_unused      = ^{fe_pc[1:0], upd_pc[1:0]};

    assign pred_pht_index   = w_pht_idx;
    assign pred_pht_entry   = r_pht[w_pht_idx];
    assign pred_taken       = r_pht[w_pht_idx][1];
    assign pred_btb_index   = w_btb_idx;
    assign pred_btb_hit     = w_hit;
    assign pred_target      = w_hit ? r_btb_tgt[w_btb_idx] : '0;
    assign pred_bhr         = r_bhr;
    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;

    // Direction state: history, counters and statistics all clear in a single cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bhr     <= '0;
            r_stat_br <= '0;
            r_stat_mp <= '0;
            for (int i = 0; i < PHT_N; i++)
                r_pht[i] <= 2'b01;
        end else if (upd_valid) begin
            r_stat_br <= r_stat_br + 32'd1;
            if (upd_mispredict)
                r_stat_mp <= r_stat_mp + 32'd1;
            if (upd_cond) begin
                r_pht[upd_pht_index] <= sat_cnt(r_pht[upd_pht_index], upd_taken);
                r_bhr <= {r_bhr[BHR_BITS-2:0], upd_taken};
            end
        end
    end

    // BTB valid bits: only taken updates allocate, nothing ever invalidates
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_N; i++)
                r_btb_vld[i] <= 1'b0;
        end else if (upd_valid && upd_taken) begin
            r_btb_vld[w_upd_btb_idx] <= 1'b1;
        end
    end

    // Tag/target payload is qualified by the valid bit, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_upd_en && upd_taken) begin
            r_btb_tag[w_upd_btb_idx] <= w_upd_tag;
            r_btb_tgt[w_upd_btb_idx] <= upd_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a behavioural model predicts each cycle's
// lookup outputs, which are queued on drive and compared on the following negedge.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fe_pc;
    logic        pred_taken, pred_btb_hit;
    logic [31:0] pred_target;
    logic [7:0]  pred_bhr, pred_pht_index;
    logic [1:0]  pred_pht_entry;
    logic [3:0]  pred_btb_index;
    logic        upd_valid, upd_cond, upd_taken, upd_mispredict;
    logic [31:0] upd_pc, upd_target;
    logic [7:0]  upd_pht_index;
    logic [31:0] stat_branches, stat_mispredicts;

    always #5 clk = ~clk;

    branch_predictor #(.DBITS(32), .BHR_BITS(8), .BTB_IDX_BITS(4)) dut (
        .clk(clk), .reset(reset), .fe_pc(fe_pc),
        .pred_taken(pred_taken), .pred_btb_hit(pred_btb_hit), .pred_target(pred_target),
        .pred_bhr(pred_bhr), .pred_pht_index(pred_pht_index), .pred_pht_entry(pred_pht_entry),
        .pred_btb_index(pred_btb_index),
        .upd_valid(upd_valid), .upd_cond(upd_cond), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pht_index(upd_pht_index), .upd_mispredict(upd_mispredict),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    typedef struct {
        logic [7:0]  idx;
        logic [1:0]  ent;
        logic        tk;
        logic        hit;
        logic [31:0] tgt;
        logic [7:0]  bhr;
        logic [3:0]  bi;
        logic [31:0] br;
        logic [31:0] mp;
    } exp_t;

    exp_t sb[$];

    logic [1:0]  m_pht [256];
    logic        m_v   [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic [7:0]  m_bhr;
    logic [31:0] m_br, m_mp;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  a_idx, a_bhr;
    logic [1:0]  a_ent;
    logic        a_hit, a_tk;
    logic [31:0] a_tgt, a_br, a_mp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
        for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        m_bhr = '0; m_br = '0; m_mp = '0;
    endtask

    task automatic step(input logic [31:0] pc, input logic rst_in, input logic uv,
                        input logic uc, input logic ut, input logic [31:0] upc,
                        input logic [31:0] utgt, input logic [7:0] uidx, input logic um);
        exp_t e, g;
        logic [3:0] bi;
        @(posedge clk); #1;
        fe_pc = pc; reset = rst_in; upd_valid = uv; upd_cond = uc; upd_taken = ut;
        upd_pc = upc; upd_target = utgt; upd_pht_index = uidx; upd_mispredict = um;
        bi    = pc[5:2];
        e.idx = pc[9:2] ^ m_bhr;
        e.ent = m_pht[e.idx];
        e.tk  = e.ent[1];
        e.bi  = bi;
        e.hit = m_v[bi] && (m_tag[bi] == pc[31:6]);
        e.tgt = e.hit ? m_tgt[bi] : 32'd0;
        e.bhr = m_bhr;
        e.br  = m_br;
        e.mp  = m_mp;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        chk("pht_index", {24'd0, pred_pht_index}, {24'd0, g.idx});
        chk("pht_entry", {30'd0, pred_pht_entry}, {30'd0, g.ent});
        chk("taken", {31'd0, pred_taken}, {31'd0, g.tk});
        chk("btb_hit", {31'd0, pred_btb_hit}, {31'd0, g.hit});
        chk("target", pred_target, g.tgt);
        chk("bhr", {24'd0, pred_bhr}, {24'd0, g.bhr});
        chk("btb_index", {28'd0, pred_btb_index}, {28'd0, g.bi});
        chk("stat_br", stat_branches, g.br);
        chk("stat_mp", stat_mispredicts, g.mp);
        a_idx = pred_pht_index; a_ent = pred_pht_entry; a_tk = pred_taken;
        a_hit = pred_btb_hit; a_tgt = pred_target; a_bhr = pred_bhr;
        a_br = stat_branches; a_mp = stat_mispredicts;
        // the DUT commits this cycle's update at the next posedge
        if (rst_in) begin
            model_reset();
        end else if (uv) begin
            m_br = m_br + 1;
            if (um) m_mp = m_mp + 1;
            if (uc) begin
                if (ut && m_pht[uidx] != 2'b11) m_pht[uidx] = m_pht[uidx] + 2'b01;
                if (!ut && m_pht[uidx] != 2'b00) m_pht[uidx] = m_pht[uidx] - 2'b01;
                m_bhr = {m_bhr[6:0], ut};
            end
            if (ut) begin
                m_v[upc[5:2]] = 1'b1;
                m_tag[upc[5:2]] = upc[31:6];
                m_tgt[upc[5:2]] = utgt;
            end
        end
    endtask

    task automatic idle(input logic [31:0] pc);
        step(pc, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0, 1'b0);
    endtask

    initial begin
        int seq [6] = '{1, 2, 3, 3, 2, 1};
        logic [31:0] pcs [4] = '{32'h100, 32'h140, 32'h300, 32'h408};
        logic [31:0] cpc;
        reset = 1'b1; fe_pc = '0; upd_valid = 1'b0; upd_cond = 1'b0; upd_taken = 1'b0;
        upd_pc = '0; upd_target = '0; upd_pht_index = '0; upd_mispredict = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // post-reset lookup
        idle(32'h100);
        chk("rst_index", {24'd0, a_idx}, 32'h40);
        chk("rst_hit", {31'd0, a_hit}, 32'd0);
        chk("rst_taken", {31'd0, a_tk}, 32'd0);
        chk("rst_entry", {30'd0, a_ent}, 32'd1);
        chk("rst_target", a_tgt, 32'd0);

        // conditional taken update, then lookups at 0x104 and 0x100
        step(32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 8'h40, 1'b1);
        chk("same_cyc_hit", {31'd0, a_hit}, 32'd0);
        idle(32'h104);
        chk("hit_104", {31'd0, a_hit}, 32'd0);
        chk("bhr_1", {24'd0, a_bhr}, 32'd1);
        chk("index_104", {24'd0, a_idx}, 32'h40);
        chk("stat_br_1", a_br, 32'd1);
        chk("stat_mp_1", a_mp, 32'd1);
        idle(32'h100);
        chk("hit_100", {31'd0, a_hit}, 32'd1);
        chk("target_100", a_tgt, 32'h200);
        chk("index_100", {24'd0, a_idx}, 32'h41);

        // saturating counter at index 0x10: 3 taken then 2 not-taken
        for (int k = 0; k < 6; k++) begin
            cpc = {22'd0, 8'h10 ^ m_bhr, 2'b00};
            if (k < 5)
                step(cpc, 1'b0, 1'b1, 1'b1, (k < 3), 32'h408, 32'h500, 8'h10, 1'b0);
            else
                idle(cpc);
            chk($sformatf("cnt_seq%0d", k), {30'd0, a_ent}, seq[k]);
        end

        // reset wins over a simultaneous mispredicted update
        step(32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h999, 8'h40, 1'b1);
        idle(32'h100);
        chk("rst_upd_mp", a_mp, 32'd0);
        chk("rst_upd_br", a_br, 32'd0);
        chk("rst_upd_bhr", {24'd0, a_bhr}, 32'd0);
        chk("rst_upd_hit", {31'd0, a_hit}, 32'd0);
        chk("rst_upd_entry", {30'd0, a_ent}, 32'd1);

        // unconditional jump: BTB written, BHR/PHT untouched
        step(32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h80, 8'h40, 1'b0);
        idle(32'h300);
        chk("jmp_hit", {31'd0, a_hit}, 32'd1);
        chk("jmp_target", a_tgt, 32'h80);
        chk("jmp_bhr", {24'd0, a_bhr}, 32'd0);
        chk("jmp_entry", {30'd0, a_ent}, 32'd1);
        chk("jmp_stat_br", a_br, 32'd1);

        // aliasing: 0x140 evicts 0x100 from the shared BTB slot
        step(32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 8'h00, 1'b0);
        step(32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h140, 32'h600, 8'h00, 1'b0);
        chk("alias_old_hit", {31'd0, a_hit}, 32'd1);
        chk("alias_old_tgt", a_tgt, 32'h200);
        idle(32'h100);
        chk("alias_miss", {31'd0, a_hit}, 32'd0);
        step(32'h140, 1'b0, 1'b1, 1'b1, 1'b0, 32'h140, 32'h0, 8'h22, 1'b0);
        idle(32'h140);
        chk("nt_keeps_btb", {31'd0, a_hit}, 32'd1);
        chk("nt_keeps_tgt", a_tgt, 32'h600);

        // randomized traffic checked by the scoreboard alone
        for (int r = 0; r < 60; r++) begin
            step(pcs[$urandom_range(0, 3)] + 32'($urandom_range(0, 3) * 4), 1'b0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 pcs[$urandom_range(0, 3)], $urandom, 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end
        idle(32'h100);

        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_drain: got %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
